// File: rtl/tmds_symbol_aligner_decoder_if.sv
// Per-channel TMDS receive bus: the unaligned deserializer word in, and the aligned, classified symbol out.
interface tmds_symbol_aligner_decoder_if;
  logic [9:0] raw_word;
  logic [9:0] symbol;
  logic [7:0] video_data;
  logic [1:0] ctrl;
  logic [3:0] terc4;
  logic       is_ctrl;
  logic       is_terc4;
  logic       locked;
  logic [3:0] bit_offset;

  modport master (
    output raw_word,
    input  symbol, video_data, ctrl, terc4, is_ctrl, is_terc4, locked, bit_offset
  );

  modport slave (
    input  raw_word,
    output symbol, video_data, ctrl, terc4, is_ctrl, is_terc4, locked, bit_offset
  );
endinterface

// File: rtl/tmds_symbol_aligner_decoder.sv
// TMDS channel receiver: bit-slips a 20-bit window until control-token runs appear, then
// decodes each aligned symbol as video byte, control token or TERC4 nibble.
module tmds_symbol_aligner_decoder #(
  parameter int unsigned LOCK_RUN       = 8,
  parameter int unsigned SEARCH_TIMEOUT = 4096
) (
  input  logic                          clk_pixel,
  input  logic                          reset_n,
  tmds_symbol_aligner_decoder_if.slave  bus
);
  localparam int unsigned TW = $clog2(SEARCH_TIMEOUT + 1);
  localparam int unsigned RW = $clog2(LOCK_RUN + 1);

  typedef enum logic {SEARCH, LOCKED} state_t;

  state_t         state_q, state_d;
  logic [9:0]     raw_prev_q, raw_prev_d;
  logic [9:0]     symbol_q, symbol_d;
  logic [7:0]     video_q, video_d;
  logic [1:0]     ctrl_q, ctrl_d;
  logic [3:0]     terc4_q, terc4_d;
  logic           is_ctrl_q, is_ctrl_d;
  logic           is_terc4_q, is_terc4_d;
  logic           locked_q, locked_d;
  logic [3:0]     offset_q, offset_d;
  logic [RW-1:0]  run_q, run_d;
  logic [TW-1:0]  tmo_q, tmo_d;
  logic [1:0]     flush_q, flush_d;

  logic [19:0]    win;
  logic [7:0]     q;
  logic           run_done;
  logic           timeout;

  always_comb begin
    raw_prev_d = bus.raw_word;
    win        = {bus.raw_word, raw_prev_q};
    symbol_d   = win[offset_q +: 10];

    q          = symbol_q[9] ? ~symbol_q[7:0] : symbol_q[7:0];
    video_d    = '0;
    video_d[0] = q[0];
    for (int unsigned i = 1; i < 8; i++) begin
      video_d[i] = symbol_q[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
    end

    ctrl_d     = '0;
    terc4_d    = '0;
    is_ctrl_d  = 1'b0;
    is_terc4_d = 1'b0;
    case (symbol_q)
      10'b1101010100: begin is_ctrl_d = 1'b1; ctrl_d = 2'd0; end
      10'b0010101011: begin is_ctrl_d = 1'b1; ctrl_d = 2'd1; end
      10'b0101010100: begin is_ctrl_d = 1'b1; ctrl_d = 2'd2; end
      10'b1010101011: begin is_ctrl_d = 1'b1; ctrl_d = 2'd3; end
      10'b1010011100: begin is_terc4_d = 1'b1; terc4_d = 4'h0; end
      10'b1001100011: begin is_terc4_d = 1'b1; terc4_d = 4'h1; end
      10'b1011100100: begin is_terc4_d = 1'b1; terc4_d = 4'h2; end
      10'b1011100010: begin is_terc4_d = 1'b1; terc4_d = 4'h3; end
      10'b0101110001: begin is_terc4_d = 1'b1; terc4_d = 4'h4; end
      10'b0100011110: begin is_terc4_d = 1'b1; terc4_d = 4'h5; end
      10'b0110001110: begin is_terc4_d = 1'b1; terc4_d = 4'h6; end
      10'b0100111100: begin is_terc4_d = 1'b1; terc4_d = 4'h7; end
      10'b1011001100: begin is_terc4_d = 1'b1; terc4_d = 4'h8; end
      10'b0100111001: begin is_terc4_d = 1'b1; terc4_d = 4'h9; end
      10'b0110011100: begin is_terc4_d = 1'b1; terc4_d = 4'hA; end
      10'b1011000110: begin is_terc4_d = 1'b1; terc4_d = 4'hB; end
      10'b1010001110: begin is_terc4_d = 1'b1; terc4_d = 4'hC; end
      10'b1001110001: begin is_terc4_d = 1'b1; terc4_d = 4'hD; end
      10'b0101100011: begin is_terc4_d = 1'b1; terc4_d = 4'hE; end
      10'b1011000011: begin is_terc4_d = 1'b1; terc4_d = 4'hF; end
      default: ;
    endcase

    // Two cycles after a slip is_ctrl_q still reflects the old alignment, so it must not count.
    run_done = (flush_q == 2'd0) && is_ctrl_q && (run_q == RW'(LOCK_RUN - 1));
    timeout  = (tmo_q == TW'(SEARCH_TIMEOUT - 1));

    flush_d  = (flush_q == 2'd0) ? 2'd0 : flush_q - 2'd1;
    if (flush_q != 2'd0 || !is_ctrl_q) begin
      run_d = '0;
    end else if (run_q != RW'(LOCK_RUN)) begin
      run_d = run_q + RW'(1);
    end else begin
      run_d = run_q;
    end

    tmo_d    = tmo_q + TW'(1);
    offset_d = offset_q;
    state_d  = state_q;
    if (run_done) begin
      tmo_d   = '0;
      state_d = LOCKED;
    end else if (timeout) begin
      tmo_d    = '0;
      run_d    = '0;
      flush_d  = 2'd2;
      offset_d = (offset_q == 4'd9) ? 4'd0 : offset_q + 4'd1;
      state_d  = SEARCH;
    end
    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk_pixel) begin
    if (!reset_n) begin
      state_q    <= SEARCH;
      raw_prev_q <= '0;
      symbol_q   <= '0;
      video_q    <= '0;
      ctrl_q     <= '0;
      terc4_q    <= '0;
      is_ctrl_q  <= 1'b0;
      is_terc4_q <= 1'b0;
      locked_q   <= 1'b0;
      offset_q   <= '0;
      run_q      <= '0;
      tmo_q      <= '0;
      flush_q    <= '0;
    end else begin
      state_q    <= state_d;
      raw_prev_q <= raw_prev_d;
      symbol_q   <= symbol_d;
      video_q    <= video_d;
      ctrl_q     <= ctrl_d;
      terc4_q    <= terc4_d;
      is_ctrl_q  <= is_ctrl_d;
      is_terc4_q <= is_terc4_d;
      locked_q   <= locked_d;
      offset_q   <= offset_d;
      run_q      <= run_d;
      tmo_q      <= tmo_d;
      flush_q    <= flush_d;
    end
  end

  assign bus.symbol     = symbol_q;
  assign bus.video_data = video_q;
  assign bus.ctrl       = ctrl_q;
  assign bus.terc4      = terc4_q;
  assign bus.is_ctrl    = is_ctrl_q;
  assign bus.is_terc4   = is_terc4_q;
  assign bus.locked     = locked_q;
  assign bus.bit_offset = offset_q;
endmodule

// File: tb/tb_tmds_symbol_aligner_decoder.sv
// Directed bench for the TMDS aligner/decoder: alignment search, lock, decode tables, lock loss, reset.
module tb_tmds_symbol_aligner_decoder;
  localparam logic [9:0] TOK0 = 10'b1101010100;
  localparam logic [9:0] TOK1 = 10'b0010101011;
  localparam logic [9:0] TOK2 = 10'b0101010100;
  localparam logic [9:0] TOK3 = 10'b1010101011;
  localparam logic [9:0] VID  = 10'b0100000000;

  logic clk_pixel = 1'b0;
  logic reset_n   = 1'b0;
  int   n_tests   = 0;
  int   n_fail    = 0;
  int   cyc       = 0;
  int   rot       = 0;
  logic [9:0] prev_sym = VID;

  logic [9:0] terc_tab [16] = '{
    10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
    10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
    10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
    10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
  };
  logic [9:0] tok_tab [4] = '{TOK0, TOK1, TOK2, TOK3};

  tmds_symbol_aligner_decoder_if bus ();

  tmds_symbol_aligner_decoder #(
    .LOCK_RUN       (8),
    .SEARCH_TIMEOUT (4096)
  ) dut (
    .clk_pixel (clk_pixel),
    .reset_n   (reset_n),
    .bus       (bus)
  );

  always #5 clk_pixel = ~clk_pixel;
  always @(posedge clk_pixel) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Serialises symbol s into the stream, delayed by rot bits relative to word boundaries.
  task automatic feed(input logic [9:0] s);
    logic [19:0] pair;
    pair         = {s, prev_sym};
    bus.raw_word = 10'(pair >> (10 - rot));
    prev_sym     = s;
    @(posedge clk_pixel);
    #1;
  endtask

  task automatic check_decode(input string tag, input logic [9:0] s, input logic chk_vd,
                              input logic [7:0] vd, input logic [1:0] c, input logic [3:0] t,
                              input logic ic, input logic it);
    feed(s);
    feed(VID);
    check({tag, "_sym"}, 32'(bus.symbol), 32'(s));
    feed(VID);
    if (chk_vd) check({tag, "_vd"}, 32'(bus.video_data), 32'(vd));
    check({tag, "_ctrl"}, 32'(bus.ctrl), 32'(c));
    check({tag, "_terc4"}, 32'(bus.terc4), 32'(t));
    check({tag, "_isctrl"}, 32'(bus.is_ctrl), 32'(ic));
    check({tag, "_isterc"}, 32'(bus.is_terc4), 32'(it));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_locked"}, 32'(bus.locked), 0);
    check({tag, "_offset"}, 32'(bus.bit_offset), 0);
    check({tag, "_sym"}, 32'(bus.symbol), 0);
    check({tag, "_vd"}, 32'(bus.video_data), 0);
    check({tag, "_ctrl"}, 32'(bus.ctrl), 0);
    check({tag, "_terc4"}, 32'(bus.terc4), 0);
    check({tag, "_isctrl"}, 32'(bus.is_ctrl), 0);
    check({tag, "_isterc"}, 32'(bus.is_terc4), 0);
  endtask

  task automatic lock_run(input string tag);
    for (int k = 1; k <= 12; k++) begin
      feed(TOK0);
      if (k == 10) check({tag, "_prelock"}, 32'(bus.locked), 0);
      if (k == 11) begin
        check({tag, "_lock"}, 32'(bus.locked), 1);
        check({tag, "_ctrl"}, 32'(bus.ctrl), 0);
        check({tag, "_isctrl"}, 32'(bus.is_ctrl), 1);
      end
    end
    check({tag, "_offset"}, 32'(bus.bit_offset), 0);
  endtask

  initial begin
    int lock_cyc;
    int n_chg;
    int chg_cyc [10];
    int chg_off [10];
    logic [3:0] last_off;
    int i;

    bus.raw_word = 10'h2A5;
    repeat (2) @(posedge clk_pixel);
    #1;
    check_all_zero("reset");
    reset_n = 1'b1;

    // Aligned start
    repeat (100) feed(VID);
    lock_run("aligned");
    lock_cyc = cyc - 1;

    check_decode("vid00", 10'b0100000000, 1'b1, 8'h00, 2'd0, 4'h0, 1'b0, 1'b0);
    check_decode("vidFE", 10'b1011111111, 1'b1, 8'hFE, 2'd0, 4'h0, 1'b0, 1'b0);
    check_decode("vidEE", 10'b0011110000, 1'b1, 8'hEE, 2'd0, 4'h0, 1'b0, 1'b0);
    check_decode("vid10", 10'b1100001111, 1'b1, 8'h10, 2'd0, 4'h0, 1'b0, 1'b0);
    for (int k = 0; k < 16; k++)
      check_decode($sformatf("terc%0d", k), terc_tab[k], 1'b0, 8'h00, 2'd0, 4'(k), 1'b0, 1'b1);

    // Loss of lock: video only until the search timeout expires
    i = 0;
    while (bus.locked && i < 5000) begin
      feed(VID);
      i++;
    end
    check("loss_locked", 32'(bus.locked), 0);
    check("loss_interval", 32'(cyc - lock_cyc), 4096);
    check("loss_offset", 32'(bus.bit_offset), 1);

    // Misaligned stream, 3-bit rotation, periodic control runs
    reset_n = 1'b0;
    feed(VID);
    reset_n  = 1'b1;
    rot      = 3;
    n_chg    = 0;
    last_off = bus.bit_offset;
    i = 0;
    while (!bus.locked && i < 20000) begin
      feed((i % 858 < 12) ? TOK0 : VID);
      if (bus.bit_offset != last_off && n_chg < 10) begin
        chg_cyc[n_chg] = cyc;
        chg_off[n_chg] = int'(bus.bit_offset);
        n_chg++;
      end
      last_off = bus.bit_offset;
      i++;
    end
    check("mis_locked", 32'(bus.locked), 1);
    check("mis_offset", 32'(bus.bit_offset), 3);
    check("mis_nslips", 32'(n_chg), 3);
    if (n_chg >= 3) begin
      check("mis_step1", 32'(chg_off[0]), 1);
      check("mis_step2", 32'(chg_off[1]), 2);
      check("mis_step3", 32'(chg_off[2]), 3);
      check("mis_gap12", 32'(chg_cyc[1] - chg_cyc[0]), 4096);
      check("mis_gap23", 32'(chg_cyc[2] - chg_cyc[1]), 4096);
    end
    for (int k = 0; k < 4; k++)
      check_decode($sformatf("tok%0d", k), tok_tab[k], 1'b0, 8'h00, 2'(k), 4'h0, 1'b1, 1'b0);

    // Move the stream to a 5-bit rotation and relock there
    rot = 5;
    i = 0;
    while (!(bus.locked && bus.bit_offset == 4'd5) && i < 20000) begin
      feed((i % 858 < 12) ? TOK0 : VID);
      i++;
    end
    check("off5_locked", 32'(bus.locked), 1);
    check("off5_offset", 32'(bus.bit_offset), 5);

    // One-cycle reset while locked
    reset_n = 1'b0;
    feed(TOK0);
    reset_n = 1'b1;
    check_all_zero("midreset");

    rot      = 0;
    prev_sym = VID;
    repeat (20) feed(VID);
    lock_run("relock");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
